// File: rtl/s3_csee_chien_forney_pkg.sv
// Shared GF(2^8) definitions for the Chien search / Forney stage:
// field constants, a bit-serial multiply helper and the start-position
// dependent initial values of the Chien terms.
package s3_csee_chien_forney_pkg;

    localparam logic [8:0] GF_POLY      = 9'h11D;   // x^8+x^4+x^3+x^2+1
    localparam logic [7:0] GF_ALPHA     = 8'h02;
    localparam logic [7:0] GF_ALPHA2    = 8'h04;
    localparam logic [7:0] GF_ALPHA_INV = 8'h8E;    // 02 * 8E = 01

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_LOAD   = 4'b0010,
        ST_SEARCH = 4'b0100,
        ST_DONE   = 4'b1000
    } csee_state_e;

    // Shift-and-add product of two field elements, reduced by GF_POLY.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) begin
                acc = acc ^ sh;
            end else begin
                acc = acc;
            end
            if (sh[7]) begin
                sh = {sh[6:0], 1'b0} ^ GF_POLY[7:0];
            end else begin
                sh = {sh[6:0], 1'b0};
            end
        end
        return acc;
    endfunction

    // alpha^e for any non-negative exponent (alpha has order 255).
    function automatic logic [7:0] gf_alpha_pow(input int e);
        logic [7:0] r;
        int         em;
        em = e % 255;
        r  = 8'h01;
        for (int k = 0; k < 255; k++) begin
            if (k < em) begin
                r = gf_mul(r, GF_ALPHA);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Default start position for a codeword of n symbols.
    function automatic int default_first_pos(input int n);
        return n - 1;
    endfunction

    // alpha^-(first_pos): scales lambda1 to the first searched position.
    function automatic logic [7:0] init_t1(input int first_pos);
        return gf_alpha_pow((255 - (first_pos % 255)) % 255);
    endfunction

    // alpha^-(2*first_pos): scales lambda2 to the first searched position.
    function automatic logic [7:0] init_t2(input int first_pos);
        return gf_alpha_pow((255 - ((2 * first_pos) % 255)) % 255);
    endfunction

    // alpha^(first_pos): scales omega0 to the first searched position.
    function automatic logic [7:0] init_w(input int first_pos);
        return gf_alpha_pow(first_pos % 255);
    endfunction

endpackage

// File: rtl/gf2m8_inv.sv
// Combinational GF(2^8) inverse: y = a^254, which also maps 00 to 00.
module gf2m8_inv
    import s3_csee_chien_forney_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    logic [7:0] pow_s;
    logic [7:0] acc_s;

    // a^254 = a^2 * a^4 * ... * a^128 via repeated squaring.
    always_comb begin
        pow_s = a_i;
        acc_s = 8'h01;
        for (int k = 1; k < 8; k++) begin
            pow_s = gf_mul(pow_s, pow_s);
            acc_s = gf_mul(acc_s, pow_s);
        end
        y_o = acc_s;
    end

endmodule

// File: rtl/gf2m8_multi.sv
// Combinational GF(2^8) multiplier over the 0x11D field.
module gf2m8_multi
    import s3_csee_chien_forney_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] y_o
);

    // Field product of the two operands.
    always_comb begin
        y_o = gf_mul(a_i, b_i);
    end

endmodule

// File: rtl/s3_csee_chien_forney.sv
// Chien search plus Forney magnitude for up to two symbol errors.
// Latches the KES result, steps the locator terms through every
// position from FIRST_POS down to 0 and streams one magnitude per cycle.
module s3_csee_chien_forney
    import s3_csee_chien_forney_pkg::*;
#(
    parameter int N         = 255,
    parameter int FIRST_POS = default_first_pos(N)
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       kes_done,
    input  logic [7:0] rs_lambda0,
    input  logic [7:0] rs_lambda1,
    input  logic [7:0] rs_lambda2,
    input  logic [7:0] rs_omega0,
    input  logic [7:0] rs_omega1,
    output logic       err_vld,
    output logic [7:0] err_val,
    output logic [7:0] err_pos,
    output logic       csee_done,
    output logic [1:0] err_cnt,
    output logic       dec_fail
);

    localparam logic [7:0] T1_INIT  = init_t1(FIRST_POS);
    localparam logic [7:0] T2_INIT  = init_t2(FIRST_POS);
    localparam logic [7:0] W_INIT   = init_w(FIRST_POS);
    localparam logic [7:0] POS_INIT = 8'(FIRST_POS);
    localparam logic [7:0] LAST_CNT = 8'(N - 1);

    csee_state_e state_q, state_d;

    logic [7:0] l0_q, l1_q, l2_q, o0_q, o1_q;
    logic [7:0] t1_q, t2_q, w_q, inv_l1_q;
    logic [7:0] pos_q, step_q;
    logic [1:0] roots_q;

    logic       err_vld_q, csee_done_q, dec_fail_q;
    logic [7:0] err_val_q, err_pos_q;
    logic [1:0] err_cnt_q;

    logic       latch_s, load_s, search_s, done_s;
    logic       last_s, root_s, fail_s;
    logic [1:0] deg_s;
    logic [7:0] m1_a_s, m1_b_s, m2_a_s, m2_b_s, mw_a_s, mw_b_s;
    logic [7:0] p1_s, p2_s, pw_s, inv_s, forney_s;

    // Shared multipliers: initial scaling in LOAD, per-step rotation in SEARCH.
    gf2m8_multi u_mul_t1 (.a_i(m1_a_s), .b_i(m1_b_s), .y_o(p1_s));
    gf2m8_multi u_mul_t2 (.a_i(m2_a_s), .b_i(m2_b_s), .y_o(p2_s));
    gf2m8_multi u_mul_w  (.a_i(mw_a_s), .b_i(mw_b_s), .y_o(pw_s));
    gf2m8_multi u_mul_fy (.a_i(w_q ^ o1_q), .b_i(inv_l1_q), .y_o(forney_s));
    gf2m8_inv   u_inv_l1 (.a_i(l1_q), .y_o(inv_s));

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; SEARCH ends after the position-0 step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = kes_done ? ST_LOAD : ST_IDLE;
            ST_LOAD:   state_d = ST_SEARCH;
            ST_SEARCH: state_d = last_s ? ST_DONE : ST_SEARCH;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State decode into control strobes; kes_done only counts in IDLE.
    always_comb begin
        latch_s  = 1'b0;
        load_s   = 1'b0;
        search_s = 1'b0;
        done_s   = 1'b0;
        case (state_q)
            ST_IDLE:   latch_s  = kes_done;
            ST_LOAD:   load_s   = 1'b1;
            ST_SEARCH: search_s = 1'b1;
            ST_DONE:   done_s   = 1'b1;
            default:   latch_s  = 1'b0;
        endcase
    end

    // Operand selection, root test, degree and failure decision.
    always_comb begin
        if (load_s) begin
            m1_a_s = l1_q; m1_b_s = T1_INIT;
            m2_a_s = l2_q; m2_b_s = T2_INIT;
            mw_a_s = o0_q; mw_b_s = W_INIT;
        end else begin
            m1_a_s = t1_q; m1_b_s = GF_ALPHA;
            m2_a_s = t2_q; m2_b_s = GF_ALPHA2;
            mw_a_s = w_q;  mw_b_s = GF_ALPHA_INV;
        end
        last_s = (step_q == LAST_CNT);
        root_s = ((l0_q ^ t1_q ^ t2_q) == 8'h00);
        if (l2_q != 8'h00) begin
            deg_s = 2'd2;
        end else if (l1_q != 8'h00) begin
            deg_s = 2'd1;
        end else begin
            deg_s = 2'd0;
        end
        fail_s = (roots_q != deg_s) || ((l1_q == 8'h00) && (deg_s == 2'd2));
    end

    // Coefficient capture from the KES stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            l0_q <= 8'h00; l1_q <= 8'h00; l2_q <= 8'h00;
            o0_q <= 8'h00; o1_q <= 8'h00;
        end else if (latch_s) begin
            l0_q <= rs_lambda0; l1_q <= rs_lambda1; l2_q <= rs_lambda2;
            o0_q <= rs_omega0;  o1_q <= rs_omega1;
        end else begin
            l0_q <= l0_q; l1_q <= l1_q; l2_q <= l2_q;
            o0_q <= o0_q; o1_q <= o1_q;
        end
    end

    // Chien terms, position tracking and saturating root count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            t1_q <= 8'h00; t2_q <= 8'h00; w_q <= 8'h00; inv_l1_q <= 8'h00;
            pos_q <= 8'h00; step_q <= 8'h00; roots_q <= 2'd0;
        end else if (load_s) begin
            t1_q     <= p1_s;
            t2_q     <= p2_s;
            w_q      <= pw_s;
            inv_l1_q <= inv_s;
            pos_q    <= POS_INIT;
            step_q   <= 8'h00;
            roots_q  <= 2'd0;
        end else if (search_s) begin
            t1_q    <= p1_s;
            t2_q    <= p2_s;
            w_q     <= pw_s;
            pos_q   <= pos_q - 8'd1;
            step_q  <= step_q + 8'd1;
            roots_q <= (root_s && (roots_q != 2'd3)) ? roots_q + 2'd1 : roots_q;
        end else begin
            t1_q <= t1_q; t2_q <= t2_q; w_q <= w_q; inv_l1_q <= inv_l1_q;
            pos_q <= pos_q; step_q <= step_q; roots_q <= roots_q;
        end
    end

    // Registered output stream and end-of-codeword summary.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_vld_q   <= 1'b0;
            err_val_q   <= 8'h00;
            err_pos_q   <= 8'h00;
            csee_done_q <= 1'b0;
            err_cnt_q   <= 2'd0;
            dec_fail_q  <= 1'b0;
        end else begin
            err_vld_q   <= search_s;
            err_val_q   <= (search_s && root_s) ? forney_s : 8'h00;
            err_pos_q   <= search_s ? pos_q : 8'h00;
            csee_done_q <= done_s;
            err_cnt_q   <= done_s ? roots_q : 2'd0;
            dec_fail_q  <= done_s ? fail_s : 1'b0;
        end
    end

    assign err_vld   = err_vld_q;
    assign err_val   = err_val_q;
    assign err_pos   = err_pos_q;
    assign csee_done = csee_done_q;
    assign err_cnt   = err_cnt_q;
    assign dec_fail  = dec_fail_q;

endmodule
